// File: rtl/mips_fetch_pkg.sv
// Shared types and helpers for the MIPS instruction fetch front end.
package mips_fetch_pkg;

  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam int unsigned LANE_W          = 2;

  typedef enum logic [2:0] {
    F0   = 3'd0,
    F1   = 3'd1,
    F2   = 3'd2,
    F3   = 3'd3,
    HOLD = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_word_t;

  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
    return {pc[INSTR_W-1:2], 2'b00};
  endfunction

  // Byte offset within the instruction that a fetch state reads.
  function automatic logic [LANE_W-1:0] state_offset(input fetch_state_t s);
    logic [LANE_W-1:0] off;
    case (s)
      F1:      off = 2'd1;
      F2:      off = 2'd2;
      F3:      off = 2'd3;
      default: off = 2'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/fetch_word_assembler.sv
// Four-lane byte register that assembles one instruction word from byte reads.
module fetch_word_assembler
  import mips_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               wr_en_i,
  input  logic [LANE_W-1:0]  lane_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_c_o
);

  logic [INSTR_W-1:0] word_q;

  // Stored word with this cycle's byte already merged in, so the last lane can be used on the same edge.
  always_comb begin
    word_c_o = word_q;
    if (wr_en_i) word_c_o[{lane_i, 3'b000} +: 8] = byte_i;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) word_q <= '0;
    else                  word_q <= word_c_o;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Byte-serial big-endian instruction fetch with valid/ready output and PC redirect.
// Optional PREFETCH_EN: separate output register so fetching of pc+4 overlaps the hand-off.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] pc_out,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  fetch_word_t        out_q, out_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               asm_wr, asm_clr;
  logic [LANE_W-1:0]  asm_lane;
  logic [INSTR_W-1:0] asm_word;
  logic               accept;

  assign accept   = valid_q & instr_ready;
  assign asm_lane = ~state_offset(state_q);

  fetch_word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (asm_clr),
    .wr_en_i  (asm_wr),
    .lane_i   (asm_lane),
    .byte_i   (mem_rdata),
    .word_c_o (asm_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= F0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = F0;
    end else begin
      case (state_q)
        F0: state_d = F1;
        F1: state_d = F2;
        F2: state_d = F3;
`ifdef PREFETCH_EN
        F3:   state_d = (!valid_q || accept) ? F0 : HOLD;
        HOLD: if (!valid_q || accept) state_d = F0;
`else
        F3:   state_d = HOLD;
        HOLD: if (accept) state_d = F0;
`endif
        default: state_d = F0;
      endcase
    end
  end

  always_comb begin
    pc_d    = pc_q;
    out_d   = out_q;
    valid_d = valid_q;
    asm_wr  = (state_q != HOLD);
    asm_clr = 1'b0;
`ifdef PREFETCH_EN
    if (accept) valid_d = 1'b0;
    // Completed word moves out when the output slot is free; fetching of pc+4 starts at once.
    if ((state_q == F3 || state_q == HOLD) && (!valid_q || accept)) begin
      out_d.instr = asm_word;
      out_d.pc    = pc_q;
      valid_d     = 1'b1;
      pc_d        = pc_q + 32'd4;
    end
`else
    if (state_q == F3) begin
      out_d.instr = asm_word;
      valid_d     = 1'b1;
    end
    if (accept) begin
      valid_d = 1'b0;
      pc_d    = pc_q + 32'd4;
    end
    out_d.pc = pc_d;
`endif
    if (redirect_valid) begin
      pc_d     = align_pc(redirect_pc);
      valid_d  = 1'b0;
      asm_wr   = 1'b0;
      asm_clr  = 1'b1;
      out_d.pc = pc_d;
    end
    mem_addr_d = pc_d[ADDR_W-1:0] + ADDR_W'(state_offset(state_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      out_q.pc    <= RESET_PC;
      out_q.instr <= '0;
      valid_q     <= 1'b0;
      mem_addr_q  <= RESET_PC[ADDR_W-1:0];
    end else begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign instr_out   = out_q.instr;
  assign pc_out      = out_q.pc;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level fetch model.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W   = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [31:0]       instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       pc_out;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;

  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc_out         (pc_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int dut_acc  = 0;

  // Model: fetch position (pc, bytes read so far) and an output slot.
  bit          m_valid;
  int          m_cnt;
  logic [31:0] m_fpc;
  logic [31:0] m_out_pc;
  logic [31:0] m_instr;
  int          m_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [7:0] a;
    a = pc[7:0];
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  task automatic model_edge();
    bit acc;
    bit free;
    acc = m_valid && instr_ready;
    if (reset) begin
      m_valid  = 1'b0;
      m_cnt    = 0;
      m_fpc    = RESET_PC;
      m_out_pc = RESET_PC;
    end else begin
      if (acc) m_acc++;
      if (redirect_valid) begin
        m_fpc    = {redirect_pc[31:2], 2'b00};
        m_cnt    = 0;
        m_valid  = 1'b0;
        m_out_pc = m_fpc;
      end else if (PF) begin
        free = !m_valid || acc;
        if (acc) m_valid = 1'b0;
        if (m_cnt >= 3 && free) begin
          m_valid  = 1'b1;
          m_instr  = mem_word(m_fpc);
          m_out_pc = m_fpc;
          m_fpc    = m_fpc + 32'd4;
          m_cnt    = 0;
        end else if (m_cnt < 4) begin
          m_cnt++;
        end
      end else begin
        if (m_valid) begin
          if (acc) begin
            m_valid = 1'b0;
            m_fpc   = m_fpc + 32'd4;
            m_cnt   = 0;
          end
        end else if (m_cnt == 3) begin
          m_valid = 1'b1;
          m_instr = mem_word(m_fpc);
        end else begin
          m_cnt++;
        end
        m_out_pc = m_fpc;
      end
    end
  endtask

  task automatic compare();
    logic [7:0] ea;
    check("valid", 32'(instr_valid), 32'(m_valid));
    check("pc_out", pc_out, m_out_pc);
    if (m_valid) check("instr_out", instr_out, m_instr);
    if (m_cnt < 4 && (PF || !m_valid)) begin
      ea = m_fpc[7:0] + 8'(m_cnt);
      check("mem_addr", 32'(mem_addr), 32'(ea));
    end
  endtask

  task automatic tick();
    if (!reset && instr_valid && instr_ready) dut_acc++;
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic goto_fetch(input int k);
    int n;
    n = 0;
    while (!(m_cnt == k && !m_valid) && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int first;
    int last;
    int nint;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h20; mem[8'h01] = 8'h0A; mem[8'h02] = 8'h00; mem[8'h03] = 8'h0A;
    mem[8'hFC] = 8'h8C; mem[8'hFD] = 8'h08; mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h04;
    tick();
    tick();
    check("rst_instr", instr_out, 32'h0);

    // First instruction after reset
    reset       = 1'b0;
    instr_ready = 1'b1;
    repeat (3) tick();
    check("t1_not_yet", 32'(instr_valid), 32'd0);
    tick();
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_instr", instr_out, 32'h200A000A);
    check("t1_pc", pc_out, 32'h0);
    tick();
    wait_valid(12);
    check("t1_next_pc", pc_out, 32'h4);

    // Stall in HOLD, then exactly one accept
    instr_ready = 1'b0;
    repeat (6) tick();
    instr_ready = 1'b1;
    tick();
    check("t2_accepts", 32'(dut_acc), 32'(m_acc));

    // Redirect mid-fetch to an unaligned target
    goto_fetch(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0013;
    instr_ready    = 1'b0;
    tick();
    redirect_valid = 1'b0;
    check("t3_pc", pc_out, 32'h10);
    repeat (3) tick();
    check("t3_not_yet", 32'(instr_valid), 32'd0);
    tick();
    check("t3_valid", 32'(instr_valid), 32'd1);
    check("t3_instr", instr_out, mem_word(32'h10));

    // Accept and redirect on the same edge
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    check("t4_accepts", 32'(dut_acc), 32'(m_acc));
    check("t4_pc", pc_out, 32'h40);
    wait_valid(12);
    check("t4_pc_valid", pc_out, 32'h40);

    // Wrap of the byte address across the memory end
    mem[8'h00] = 8'hAA; mem[8'h01] = 8'hBB; mem[8'h02] = 8'hCC; mem[8'h03] = 8'hDD;
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_00FC;
    tick();
    redirect_valid = 1'b0;
    wait_valid(12);
    check("t5_instr0", instr_out, 32'h8C080004);
    check("t5_pc0", pc_out, 32'hFC);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_valid(12);
    check("t5_instr1", instr_out, 32'hAABBCCDD);
    check("t5_pc1", pc_out, 32'h100);

    // Reset beats a simultaneous redirect
    instr_ready = 1'b1;
    tick();
    goto_fetch(1);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    tick();
    check("t6_rst_pc", pc_out, RESET_PC);
    check("t6_rst_valid", 32'(instr_valid), 32'd0);
    reset          = 1'b0;
    redirect_valid = 1'b0;

    // Throughput with ready held high
    first = -1;
    last  = -1;
    nint  = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (instr_valid) begin
        if (first < 0) first = c;
        else if (nint < 4) begin
          check("t6_interval", 32'(c - last), PF ? 32'd4 : 32'd5);
          nint++;
        end
        last = c;
      end
    end
    check("t6_first", 32'(first), 32'd4);

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      reset          = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      instr_ready    = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    check("acc_total", 32'(dut_acc), 32'(m_acc));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
